// File: rtl/block_seq_pkg.sv
// Shared definitions for the block read sequencer: FSM states and buffer/FIFO geometry.
package block_seq_pkg;

    localparam int FIFO_DEPTH        = 4;
    localparam int BRAM_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/block_fifo.sv
// Show-ahead FIFO: the head entry is presented on o_data while o_empty is low.
// DEPTH must be a power of two so the pointers wrap naturally.
module block_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FULL_CNT);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/block_read_sequencer.sv
// Streams one pass of NUM_BLOCKS blocks from a 2-cycle-latency block buffer, credit-limited by a small FIFO.
// Optional XOR checksum output is enabled by defining BLOCK_READ_SEQ_CHECKSUM_EN.
module block_read_sequencer
    import block_seq_pkg::*;
#(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          start_in,
    output logic                          busy_out,
    output logic                          read_next_block_valid_out,
    input  logic [REGISTER_SIZE-1:0]      read_block_in,
    input  logic                          read_block_valid_in,
    output logic [REGISTER_SIZE-1:0]      block_out,
    output logic                          block_valid_out,
    input  logic                          block_ready_in,
    output logic [$clog2(NUM_BLOCKS)-1:0] block_index_out,
    output logic                          block_last_out,
    output logic                          done_out,
    output logic                          overflow_err_out
`ifdef BLOCK_READ_SEQ_CHECKSUM_EN
    ,
    output logic [REGISTER_SIZE-1:0]      checksum_out
`endif
);

    localparam int IDX_W  = $clog2(NUM_BLOCKS);
    localparam int CNT_W  = $clog2(NUM_BLOCKS + 1);
    localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_issued;
    logic [CRED_W-1:0] r_credit;
    logic [IDX_W-1:0] r_index;
    logic             r_req;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;

    logic              w_xfer;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CRED_W-1:0] w_credit_nxt;
    logic [CNT_W-1:0]  w_issued_nxt;
    logic              w_more;
    logic              w_credit_ok;

    block_fifo #(
        .WIDTH (REGISTER_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_in),
        .i_rst_n (rst_n_in),
        .i_push  (read_block_valid_in),
        .i_data  (read_block_in),
        .i_pop   (w_xfer),
        .o_data  (block_out),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign block_valid_out           = !w_fifo_empty;
    assign w_xfer                    = block_valid_out && block_ready_in;
    assign block_index_out           = r_index;
    assign block_last_out            = block_valid_out && (r_index == IDX_W'(NUM_BLOCKS - 1));
    assign busy_out                  = r_busy;
    assign done_out                  = r_done;
    assign read_next_block_valid_out = r_req;
    assign overflow_err_out          = r_overflow;

    // Credits count blocks requested but not yet handed downstream, so the FIFO can never overfill.
    assign w_credit_nxt = r_credit + CRED_W'(r_req) - CRED_W'(w_xfer);
    assign w_issued_nxt = r_issued + CNT_W'(r_req);
    assign w_more       = (w_issued_nxt < CNT_W'(NUM_BLOCKS));
    assign w_credit_ok  = (w_credit_nxt < CRED_W'(FIFO_DEPTH));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_IDLE;
            r_issued   <= '0;
            r_credit   <= '0;
            r_index    <= '0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            r_issued <= w_issued_nxt;
            r_done   <= 1'b0;
            if (w_xfer) begin
                r_index <= r_index + 1'b1;
            end
            if (read_block_valid_in && w_fifo_full && !w_xfer) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_state  <= ST_RUN;
                        r_busy   <= 1'b1;
                        r_req    <= 1'b1;
                        r_issued <= '0;
                        r_index  <= '0;
                    end
                end
                ST_RUN: begin
                    r_req <= w_more && w_credit_ok;
                    if (!w_more) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // No requests remain, so zero credits means the final block just left.
                    if (w_credit_nxt == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BLOCK_READ_SEQ_CHECKSUM_EN
    logic [REGISTER_SIZE-1:0] r_checksum;

    assign checksum_out = r_checksum;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_checksum <= '0;
        end else if ((r_state == ST_IDLE) && start_in) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum ^ block_out;
        end
    end
`endif

endmodule

// File: tb/tb_block_read_sequencer.sv
// Randomized bench for block_read_sequencer: a behavioural block buffer feeds the DUT and each pass
// is checked against the expected in-order block sequence, timing and handshake rules.
module tb_block_read_sequencer;

    localparam int RS = 32;
    localparam int NB = 8;
    localparam int IW = $clog2(NB);

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          start_in = 1'b0;
    logic          block_ready_in = 1'b0;
    logic          busy_out;
    logic          read_next_block_valid_out;
    logic          read_block_valid_in;
    logic [RS-1:0] read_block_in;
    logic [RS-1:0] block_out;
    logic          block_valid_out;
    logic [IW-1:0] block_index_out;
    logic          block_last_out;
    logic          done_out;
    logic          overflow_err_out;
`ifdef BLOCK_READ_SEQ_CHECKSUM_EN
    logic [RS-1:0] checksum_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [RS-1:0] mem [NB];

    block_read_sequencer #(
        .REGISTER_SIZE (RS),
        .NUM_BLOCKS    (NB)
    ) dut (
        .clk_in                    (clk_in),
        .rst_n_in                  (rst_n_in),
        .start_in                  (start_in),
        .busy_out                  (busy_out),
        .read_next_block_valid_out (read_next_block_valid_out),
        .read_block_in             (read_block_in),
        .read_block_valid_in       (read_block_valid_in),
        .block_out                 (block_out),
        .block_valid_out           (block_valid_out),
        .block_ready_in            (block_ready_in),
        .block_index_out           (block_index_out),
        .block_last_out            (block_last_out),
        .done_out                  (done_out),
        .overflow_err_out          (overflow_err_out)
`ifdef BLOCK_READ_SEQ_CHECKSUM_EN
        ,
        .checksum_out              (checksum_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Block buffer: wrapping read address, data returned two cycles after each request.
    logic [IW-1:0] buf_addr;
    logic          bv1, bv2;
    logic [RS-1:0] bd1, bd2;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            buf_addr <= '0;
            bv1 <= 1'b0;
            bv2 <= 1'b0;
            bd1 <= '0;
            bd2 <= '0;
        end else begin
            bv1 <= read_next_block_valid_out;
            bd1 <= mem[buf_addr];
            if (read_next_block_valid_out) buf_addr <= buf_addr + 1'b1;
            bv2 <= bv1;
            bd2 <= bd1;
        end
    end

    assign read_block_valid_in = bv2;
    assign read_block_in       = bd2;

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy_out, read_next_block_valid_out, block_valid_out, block_last_out,
                    done_out, overflow_err_out, block_index_out, block_out});
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NB; i++) mem[i] = $urandom;
    endtask

    // mode: 0 ready high, 1 ready low for 20 cycles then high, 2 toggling, 3 random
    task automatic run_pass(input int mode, input bit timing, input int repulse_at,
                            input int reset_at, input string name);
        int            k = 0;
        int            exp_n = 0;
        int            req_cnt = 0;
        bit            finished = 0;
        bit            prev_stall = 0;
        bit            prev_final = 0;
        bit            busy_ok = 1;
        bit            rdy;
        logic [RS-1:0] prev_data = '0;
        logic [IW-1:0] prev_idx = '0;
        logic          prev_last = 1'b0;
        logic [RS-1:0] xsum = '0;

        for (int i = 0; i < NB; i++) xsum ^= mem[i];
        @(negedge clk_in);
        start_in = 1'b1;
        block_ready_in = (mode == 0);
        while (!finished && k < 300) begin
            @(negedge clk_in);
            k++;
            start_in = (repulse_at == k);
            if (reset_at >= 0 && exp_n == reset_at) begin
                rst_n_in = 1'b0;
                #1;
                chk_val({name, "_reset_outs"}, all_outs(), 64'd0);
                start_in = 1'b0;
                block_ready_in = 1'b0;
                return;
            end
            if (read_next_block_valid_out) req_cnt++;
            if (!busy_out) busy_ok = 0;
            if (timing) begin
                chk_val($sformatf("%s_req_c%0d", name, k), 64'(read_next_block_valid_out), 64'(k >= 1 && k <= 8));
                chk_val($sformatf("%s_vld_c%0d", name, k), 64'(block_valid_out), 64'(k >= 4 && k <= 11));
                chk_val($sformatf("%s_done_c%0d", name, k), 64'(done_out), 64'(k == 12));
            end
            if (mode == 1 && k == 19) begin
                chk_val({name, "_stall_reqs"}, 64'(req_cnt), 64'd4);
                chk_val({name, "_stall_held"}, 64'({block_valid_out, block_index_out, overflow_err_out}),
                        64'({1'b1, IW'(0), 1'b0}));
            end
            if (prev_stall)
                chk_val({name, "_hold"}, 64'({block_valid_out, block_index_out, block_last_out, block_out}),
                        64'({1'b1, prev_idx, prev_last, prev_data}));
            if (done_out || prev_final)
                chk_val({name, "_done_after_last"}, 64'(done_out), 64'(prev_final));
            if (done_out) begin
                finished = 1;
`ifdef BLOCK_READ_SEQ_CHECKSUM_EN
                chk_val({name, "_checksum"}, 64'(checksum_out), 64'(xsum));
`endif
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k >= 20);
                2:       rdy = k[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            block_ready_in = rdy;
            prev_final = 0;
            if (block_valid_out && rdy) begin
                if (exp_n >= NB) begin
                    chk_val({name, "_extra_xfer"}, 64'd1, 64'd0);
                end else begin
                    chk_val({name, "_xfer"}, 64'({block_index_out, block_last_out, block_out}),
                            64'({IW'(exp_n), (exp_n == NB - 1), mem[exp_n]}));
                    prev_final = (exp_n == NB - 1);
                end
                exp_n++;
            end
            prev_stall = block_valid_out && !rdy;
            prev_data  = block_out;
            prev_idx   = block_index_out;
            prev_last  = block_last_out;
        end
        if (!finished) chk_val({name, "_timeout"}, 64'd0, 64'd1);
        chk_val({name, "_req_count"}, 64'(req_cnt), 64'(NB));
        chk_val({name, "_xfer_count"}, 64'(exp_n), 64'(NB));
        chk_val({name, "_busy_during"}, 64'(busy_ok), 64'd1);
        @(negedge clk_in);
        block_ready_in = 1'b0;
        chk_val({name, "_after_done"}, 64'({busy_out, done_out, overflow_err_out, block_valid_out}), 64'd0);
    endtask

    initial begin
        rst_n_in = 1'b0;
        fill_random();
        repeat (3) @(negedge clk_in);
        chk_val("reset_state", all_outs(), 64'd0);
        rst_n_in = 1'b1;

        fill_random();
        run_pass(0, 1, 0, -1, "ready_high");
        fill_random();
        run_pass(1, 0, 0, -1, "ready_low");
        fill_random();
        run_pass(2, 0, 0, -1, "toggle");
        fill_random();
        run_pass(0, 0, 3, -1, "repulse");
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_pass(3, 0, 0, -1, $sformatf("rand%0d", r));
        end

        fill_random();
        run_pass(0, 0, 0, 3, "midreset");
        repeat (2) @(negedge clk_in);
        chk_val("in_reset_outs", all_outs(), 64'd0);
        rst_n_in = 1'b1;
        run_pass(0, 1, 0, -1, "post_reset");

        for (int i = 0; i < NB; i++) mem[i] = RS'(i + 1);
        run_pass(0, 0, 0, -1, "seq1to8");
`ifdef BLOCK_READ_SEQ_CHECKSUM_EN
        chk_val("checksum_1to8_held", 64'(checksum_out), 64'd8);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
